// File: rtl/pipe_pkg.sv
// Shared pipeline types: the decoded control bundle carried ID -> EX
// plus ALU opcode constants and a side-effect squash helper.
package pipe_pkg;

    typedef struct packed {
        logic       shift_imm;
        logic [3:0] alu_op;
        logic [1:0] mem_size;
        logic       mem_enable;
        logic       mem_rw;
        logic       load_inst;
        logic       s;
        logic       rf_enable;
        logic       b_instr;
        logic       b_l;
    } ctrl_bundle;

    localparam ctrl_bundle CTRL_BUBBLE = '0;

    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0010;

    // Condition-failed instructions keep their opcode but lose every write
    function automatic ctrl_bundle kill_side_effects(input ctrl_bundle c);
        ctrl_bundle r;
        r            = c;
        r.rf_enable  = 1'b0;
        r.mem_enable = 1'b0;
        r.mem_rw     = 1'b0;
        r.load_inst  = 1'b0;
        r.s          = 1'b0;
        r.b_instr    = 1'b0;
        r.b_l        = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/hazard_detect_unit.sv
// Load-use compare: the ID instruction reads the register a load in EX
// is about to write. A flush overrides, since the ID instruction dies.
module hazard_detect_unit (
    input  logic       ex_valid,
    input  logic       ex_load_inst,
    input  logic       ex_rf_enable,
    input  logic [3:0] ex_rd,
    input  logic       id_uses_rn,
    input  logic [3:0] id_rn,
    input  logic       id_uses_rm,
    input  logic [3:0] id_rm,
    input  logic       flush,
    output logic       hazard_stall
);

    logic load_in_ex;
    logic rn_hit;
    logic rm_hit;

    assign load_in_ex   = ex_valid & ex_load_inst & ex_rf_enable;
    assign rn_hit       = id_uses_rn & (id_rn == ex_rd);
    assign rm_hit       = id_uses_rm & (id_rm == ex_rd);
    assign hazard_stall = load_in_ex & (rn_hit | rm_hit) & ~flush;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush squash
// and a saturating bubble counter.
module id_ex_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ext_hold,
    input  logic             flush,
    input  logic             id_cond_pass,
    input  logic             id_shift_imm,
    input  logic             id_mem_enable,
    input  logic             id_mem_rw,
    input  logic             id_load_inst,
    input  logic             id_s,
    input  logic             id_rf_enable,
    input  logic             id_b_instr,
    input  logic             id_b_l,
    input  logic [3:0]       id_alu_op,
    input  logic [1:0]       id_mem_size,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic [3:0]       id_rn,
    input  logic [3:0]       id_rm,
    input  logic [3:0]       id_rd,
    input  logic [DW-1:0]    id_pc,
    input  logic [DW-1:0]    id_rn_val,
    input  logic [DW-1:0]    id_rm_val,
    input  logic [DW-1:0]    id_rd_val,
    input  logic [23:0]      id_imm,
    output logic             ex_shift_imm,
    output logic             ex_mem_enable,
    output logic             ex_mem_rw,
    output logic             ex_load_inst,
    output logic             ex_s,
    output logic             ex_rf_enable,
    output logic             ex_b_instr,
    output logic             ex_b_l,
    output logic [3:0]       ex_alu_op,
    output logic [1:0]       ex_mem_size,
    output logic [3:0]       ex_rn,
    output logic [3:0]       ex_rm,
    output logic [3:0]       ex_rd,
    output logic [DW-1:0]    ex_pc,
    output logic [DW-1:0]    ex_rn_val,
    output logic [DW-1:0]    ex_rm_val,
    output logic [DW-1:0]    ex_rd_val,
    output logic [23:0]      ex_imm,
    output logic             ex_valid,
    output logic             hazard_stall,
    output logic [CNT_W-1:0] bubble_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ctrl_bundle id_ctrl;
    ctrl_bundle ex_ctrl;

    assign id_ctrl = '{
        shift_imm:  id_shift_imm,
        alu_op:     id_alu_op,
        mem_size:   id_mem_size,
        mem_enable: id_mem_enable,
        mem_rw:     id_mem_rw,
        load_inst:  id_load_inst,
        s:          id_s,
        rf_enable:  id_rf_enable,
        b_instr:    id_b_instr,
        b_l:        id_b_l
    };

    hazard_detect_unit u_hazard (
        .ex_valid     (ex_valid),
        .ex_load_inst (ex_ctrl.load_inst),
        .ex_rf_enable (ex_ctrl.rf_enable),
        .ex_rd        (ex_rd),
        .id_uses_rn   (id_uses_rn),
        .id_rn        (id_rn),
        .id_uses_rm   (id_uses_rm),
        .id_rm        (id_rm),
        .flush        (flush),
        .hazard_stall (hazard_stall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_ctrl      <= CTRL_BUBBLE;
            ex_valid     <= 1'b0;
            ex_rn        <= '0;
            ex_rm        <= '0;
            ex_rd        <= '0;
            ex_pc        <= '0;
            ex_rn_val    <= '0;
            ex_rm_val    <= '0;
            ex_rd_val    <= '0;
            ex_imm       <= '0;
            bubble_count <= '0;
        end else if (!ext_hold) begin
            // Data always follows ID; bubbles only need their control zeroed
            ex_rn     <= id_rn;
            ex_rm     <= id_rm;
            ex_rd     <= id_rd;
            ex_pc     <= id_pc;
            ex_rn_val <= id_rn_val;
            ex_rm_val <= id_rm_val;
            ex_rd_val <= id_rd_val;
            ex_imm    <= id_imm;
            if (flush) begin
                ex_ctrl  <= CTRL_BUBBLE;
                ex_valid <= 1'b0;
            end else if (hazard_stall) begin
                ex_ctrl  <= CTRL_BUBBLE;
                ex_valid <= 1'b0;
                if (bubble_count != CNT_MAX)
                    bubble_count <= bubble_count + CNT_W'(1);
            end else if (id_cond_pass) begin
                ex_ctrl  <= id_ctrl;
                ex_valid <= 1'b1;
            end else begin
                ex_ctrl  <= kill_side_effects(id_ctrl);
                ex_valid <= 1'b0;
            end
        end
    end

    assign ex_shift_imm  = ex_ctrl.shift_imm;
    assign ex_alu_op     = ex_ctrl.alu_op;
    assign ex_mem_size   = ex_ctrl.mem_size;
    assign ex_mem_enable = ex_ctrl.mem_enable;
    assign ex_mem_rw     = ex_ctrl.mem_rw;
    assign ex_load_inst  = ex_ctrl.load_inst;
    assign ex_s          = ex_ctrl.s;
    assign ex_rf_enable  = ex_ctrl.rf_enable;
    assign ex_b_instr    = ex_ctrl.b_instr;
    assign ex_b_l        = ex_ctrl.b_l;

endmodule
